// File: rtl/ballot_controller_pkg.sv
// Shared definitions for the ballot controller: lane count, FSM encodings, vote decode helper.
package ballot_controller_pkg;

  // Default number of candidate lanes
  localparam int unsigned NUM_CAND_DEF = 4;

  // Widest lane vector the popcount helper accepts
  localparam int unsigned MAX_CAND = 32;
  localparam int unsigned POP_W    = 6;

  // FSM state encodings (also exported on state_dbg)
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_GRANT   = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  // Number of set bits in a (zero-extended) lane vector
  function automatic logic [POP_W-1:0] count_ones(input logic [MAX_CAND-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_CAND; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/ballot_timer.sv
// Loadable down-counter shared by the ballot window and the lockout dead time.
module ballot_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             zero_q, zero_d;

  // Load has priority; counting stops and holds at zero
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
    zero_d = (count_d == '0);
  end

  // Counter and its registered zero flag
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      zero_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      zero_q  <= zero_d;
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/ballot_controller.sv
// Per-voter session sequencer: one fingerprint verification yields at most one granted vote.
module ballot_controller
  import ballot_controller_pkg::*;
#(
  parameter int unsigned NUM_CAND       = NUM_CAND_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 50_000_000,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mode,
  input  logic                fingerprint_valid,
  input  logic [NUM_CAND-1:0] vote_pulse,
  output logic [NUM_CAND-1:0] vote_grant,
  output logic                ballot_open,
  output logic                conflict,
  output logic                timeout,
  output logic [7:0]          votes_granted,
  output logic [1:0]          state_dbg
);

  localparam logic [CNT_W-1:0] WINDOW_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCKOUT_CYCLES - 1);

  logic [1:0]          state_q, state_d;
  logic                fp_q, fp_d;
  logic [NUM_CAND-1:0] grant_q, grant_d;
  logic                open_q, open_d;
  logic                conflict_q, conflict_d;
  logic                timeout_q, timeout_d;
  logic [7:0]          votes_q, votes_d;

  logic                t_load;
  logic [CNT_W-1:0]    t_load_val;
  logic                t_en;
  logic                t_zero;

  logic                fp_rise;
  logic [POP_W-1:0]    press_cnt;
  logic                press_one;
  logic                press_multi;

  assign fp_rise     = fingerprint_valid & ~fp_q;
  assign press_cnt   = count_ones(MAX_CAND'(vote_pulse));
  assign press_one   = (press_cnt == POP_W'(1));
  assign press_multi = (press_cnt >  POP_W'(1));

  // Single timer serves both the ballot window and the lockout
  ballot_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (t_load),
    .load_val (t_load_val),
    .en       (t_en),
    .zero     (t_zero)
  );

  // Next-state, timer control and registered output values
  always_comb begin
    state_d    = state_q;
    fp_d       = fingerprint_valid;
    grant_d    = '0;
    conflict_d = 1'b0;
    timeout_d  = 1'b0;
    votes_d    = votes_q;
    t_load     = 1'b0;
    t_load_val = '0;
    t_en       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fp_rise && !mode) begin
          state_d    = ST_ARMED;
          t_load     = 1'b1;
          t_load_val = WINDOW_LOAD;
        end
      end
      ST_ARMED: begin
        if (mode) begin
          state_d = ST_IDLE;
        end else if (press_one) begin
          state_d = ST_GRANT;
          grant_d = vote_pulse;
        end else if (press_multi) begin
          conflict_d = 1'b1;
          t_en       = 1'b1;
        end else if (t_zero) begin
          timeout_d  = 1'b1;
          state_d    = ST_LOCKOUT;
          t_load     = 1'b1;
          t_load_val = LOCK_LOAD;
        end else begin
          t_en = 1'b1;
        end
      end
      ST_GRANT: begin
        if (votes_q != 8'hFF) begin
          votes_d = votes_q + 8'd1;
        end
        state_d    = ST_LOCKOUT;
        t_load     = 1'b1;
        t_load_val = LOCK_LOAD;
      end
      ST_LOCKOUT: begin
        t_en = 1'b1;
        if (t_zero && !fingerprint_valid) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    open_d = (state_d == ST_ARMED);
  end

  // State and output registers; fp history resets high so a held finger must lift first
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fp_q       <= 1'b1;
      grant_q    <= '0;
      open_q     <= 1'b0;
      conflict_q <= 1'b0;
      timeout_q  <= 1'b0;
      votes_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      fp_q       <= fp_d;
      grant_q    <= grant_d;
      open_q     <= open_d;
      conflict_q <= conflict_d;
      timeout_q  <= timeout_d;
      votes_q    <= votes_d;
    end
  end

  assign vote_grant    = grant_q;
  assign ballot_open   = open_q;
  assign conflict      = conflict_q;
  assign timeout       = timeout_q;
  assign votes_granted = votes_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller with a 10-cycle window and 4-cycle lockout.
module tb_ballot_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic       fingerprint_valid;
  logic [3:0] vote_pulse;
  logic [3:0] vote_grant;
  logic       ballot_open;
  logic       conflict;
  logic       timeout;
  logic [7:0] votes_granted;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int exp_votes = 0;

  ballot_controller #(
    .NUM_CAND       (4),
    .TIMEOUT_CYCLES (10),
    .LOCKOUT_CYCLES (4),
    .CNT_W          (32)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .mode              (mode),
    .fingerprint_valid (fingerprint_valid),
    .vote_pulse        (vote_pulse),
    .vote_grant        (vote_grant),
    .ballot_open       (ballot_open),
    .conflict          (conflict),
    .timeout           (timeout),
    .votes_granted     (votes_granted),
    .state_dbg         (state_dbg)
  );

  always #5 clock = ~clock;

  // Advance one edge; inputs set after this take effect at the next edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_votes = 0;
  endtask

  // Lift finger, then place it: ARMED after the second edge
  task automatic arm();
    fingerprint_valid = 1'b0;
    tick();
    fingerprint_valid = 1'b1;
    tick();
    checks++;
    if (state_dbg !== 2'd1 || ballot_open !== 1'b1) begin
      errors++;
      $display("FAIL arm: state=%0d open=%b, expected state=1 open=1", state_dbg, ballot_open);
    end
  endtask

  // Release finger and wait (bounded) for IDLE
  task automatic finish_session();
    int n;
    fingerprint_valid = 1'b0;
    vote_pulse = '0;
    n = 0;
    while (state_dbg !== 2'd0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL finish_session: state=%0d after %0d cycles, expected 0", state_dbg, n);
    end
  endtask

  task automatic vote_once(input logic [3:0] v);
    arm();
    vote_pulse = v;
    tick();
    vote_pulse = '0;
    if (exp_votes < 255) exp_votes++;
    checks++;
    if (vote_grant !== v) begin
      errors++;
      $display("FAIL vote_once grant: got %b, expected %b", vote_grant, v);
    end
    finish_session();
  endtask

  task automatic test_reset();
    mode = 1'b0;
    fingerprint_valid = 1'b0;
    vote_pulse = '0;
    do_reset();
    checks++;
    if (state_dbg !== 2'd0 || vote_grant !== 4'b0 || ballot_open !== 1'b0 ||
        conflict !== 1'b0 || timeout !== 1'b0 || votes_granted !== 8'd0) begin
      errors++;
      $display("FAIL reset: state=%0d grant=%b open=%b conf=%b to=%b votes=%0d, expected all 0",
               state_dbg, vote_grant, ballot_open, conflict, timeout, votes_granted);
    end
  endtask

  task automatic test_normal_vote();
    arm();
    tick();
    tick();
    vote_pulse = 4'b0100;
    tick();
    vote_pulse = '0;
    checks++;
    if (vote_grant !== 4'b0100 || state_dbg !== 2'd2 || ballot_open !== 1'b0) begin
      errors++;
      $display("FAIL normal_grant: grant=%b state=%0d open=%b, expected 0100 2 0",
               vote_grant, state_dbg, ballot_open);
    end
    tick();
    exp_votes++;
    checks++;
    if (vote_grant !== 4'b0000 || votes_granted !== 8'd1 || state_dbg !== 2'd3) begin
      errors++;
      $display("FAIL normal_after: grant=%b votes=%0d state=%0d, expected 0000 1 3",
               vote_grant, votes_granted, state_dbg);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (state_dbg !== 2'd3) begin
      errors++;
      $display("FAIL normal_held: state=%0d with finger held, expected 3", state_dbg);
    end
    fingerprint_valid = 1'b0;
    tick();
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL normal_release: state=%0d, expected 0", state_dbg);
    end
  endtask

  task automatic test_conflict();
    arm();
    vote_pulse = 4'b0011;
    tick();
    vote_pulse = '0;
    checks++;
    if (conflict !== 1'b1 || vote_grant !== 4'b0 || ballot_open !== 1'b1 || state_dbg !== 2'd1) begin
      errors++;
      $display("FAIL conflict_pulse: conf=%b grant=%b open=%b state=%0d, expected 1 0000 1 1",
               conflict, vote_grant, ballot_open, state_dbg);
    end
    tick();
    checks++;
    if (conflict !== 1'b0 || ballot_open !== 1'b1) begin
      errors++;
      $display("FAIL conflict_clear: conf=%b open=%b, expected 0 1", conflict, ballot_open);
    end
    vote_pulse = 4'b1000;
    tick();
    vote_pulse = '0;
    exp_votes++;
    checks++;
    if (vote_grant !== 4'b1000) begin
      errors++;
      $display("FAIL conflict_regrant: grant=%b, expected 1000", vote_grant);
    end
    finish_session();
    checks++;
    if (votes_granted !== 8'(exp_votes)) begin
      errors++;
      $display("FAIL conflict_votes: votes=%0d, expected %0d", votes_granted, exp_votes);
    end
  endtask

  task automatic test_timeout();
    arm();
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (ballot_open !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: open=%b to=%b after 9 idle cycles, expected 1 0", ballot_open, timeout);
    end
    tick();
    checks++;
    if (timeout !== 1'b1 || ballot_open !== 1'b0 || state_dbg !== 2'd3) begin
      errors++;
      $display("FAIL timeout_pulse: to=%b open=%b state=%0d, expected 1 0 3", timeout, ballot_open, state_dbg);
    end
    vote_pulse = 4'b0010;
    tick();
    vote_pulse = '0;
    checks++;
    if (vote_grant !== 4'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_lock_press: grant=%b to=%b, expected 0000 0", vote_grant, timeout);
    end
    finish_session();
  endtask

  task automatic test_last_cycle_vote();
    arm();
    for (int i = 0; i < 9; i++) tick();
    vote_pulse = 4'b0001;
    tick();
    vote_pulse = '0;
    exp_votes++;
    checks++;
    if (vote_grant !== 4'b0001 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL last_cycle_vote: grant=%b to=%b, expected 0001 0", vote_grant, timeout);
    end
    finish_session();
  endtask

  task automatic test_double_vote();
    int extra;
    arm();
    vote_pulse = 4'b0001;
    tick();
    vote_pulse = '0;
    exp_votes++;
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      vote_pulse = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      tick();
      if (vote_grant !== 4'b0) extra++;
    end
    vote_pulse = '0;
    checks++;
    if (extra != 0 || state_dbg !== 2'd3) begin
      errors++;
      $display("FAIL double_vote: extra grants=%0d state=%0d, expected 0 3", extra, state_dbg);
    end
    fingerprint_valid = 1'b0;
    tick();
    checks++;
    if (state_dbg !== 2'd0 || votes_granted !== 8'(exp_votes)) begin
      errors++;
      $display("FAIL double_release: state=%0d votes=%0d, expected 0 %0d", state_dbg, votes_granted, exp_votes);
    end
  endtask

  task automatic test_mode_abort();
    arm();
    mode = 1'b1;
    vote_pulse = 4'b0100;
    tick();
    vote_pulse = '0;
    checks++;
    if (state_dbg !== 2'd0 || ballot_open !== 1'b0 || vote_grant !== 4'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL mode_abort: state=%0d open=%b grant=%b to=%b, expected 0 0 0000 0",
               state_dbg, ballot_open, vote_grant, timeout);
    end
    mode = 1'b0;
    tick();
    tick();
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL mode_no_rearm: state=%0d with finger still held, expected 0", state_dbg);
    end
    finish_session();
  endtask

  task automatic test_fp_through_reset();
    fingerprint_valid = 1'b1;
    do_reset();
    tick();
    tick();
    checks++;
    if (state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL fp_reset_hold: state=%0d, expected 0", state_dbg);
    end
    arm();
    finish_session();
  endtask

  task automatic test_midsession_reset();
    arm();
    vote_pulse = 4'b0010;
    tick();
    vote_pulse = '0;
    do_reset();
    tick();
    checks++;
    if (votes_granted !== 8'd0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL midsession_reset: votes=%0d state=%0d, expected 0 0", votes_granted, state_dbg);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] v;
    do_reset();
    for (int s = 0; s < 260; s++) begin
      v = 4'b0001 << (s % 4);
      vote_once(v);
    end
    checks++;
    if (votes_granted !== 8'd255 || exp_votes != 255) begin
      errors++;
      $display("FAIL saturation: votes=%0d, expected 255", votes_granted);
    end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_normal_vote();
    test_conflict();
    test_timeout();
    test_last_cycle_vote();
    test_double_vote();
    test_mode_abort();
    test_fp_through_reset();
    test_midsession_reset();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
